// File: rtl/ikaopll_i2s_out_pkg.sv
// Shared widths, format codes and sample-conditioning helpers for the OPLL I2S output path.
package ikaopll_i2s_out_pkg;

  localparam int ACC_W      = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int CNT_W      = 8;
  localparam int EXT_W      = ACC_W + 3;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  localparam logic signed [EXT_W-1:0] SAT_HI  = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_LO  = EXT_W'(-32768);
  localparam logic [ACC_W-1:0]        MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  // Shift by up to 3 in a 19-bit signed space so no magnitude is lost before clamping.
  function automatic logic [ACC_W-1:0] sat_shift(input logic [ACC_W-1:0] x,
                                                 input logic [1:0]       sh);
    logic signed [EXT_W-1:0] ext;
    ext = {{3{x[ACC_W-1]}}, x};
    ext = ext <<< sh;
    if (ext > SAT_HI)
      return MAX_POS;
    else if (ext < SAT_LO)
      return MAX_NEG;
    else
      return ext[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ikaopll_i2s_out_if.sv
// Sample-in / serial-out signal bundle between the DAC stage, this block and the codec pins.
interface ikaopll_i2s_out_if;
  import ikaopll_i2s_out_pkg::*;

  logic              i_ACC_SIGNED_STRB;
  logic [ACC_W-1:0]  i_ACC_SIGNED;
  logic [1:0]        i_GAIN_SHIFT;
  logic              i_FMT;

  logic              o_I2S_BCLK;
  logic              o_I2S_LRCK;
  logic              o_I2S_SDATA;
  logic              o_FRAME_STRB;
  logic [CNT_W-1:0]  o_OVERRUN_CNT;
  logic [CNT_W-1:0]  o_UNDERRUN_CNT;

  modport master (
    output i_ACC_SIGNED_STRB, i_ACC_SIGNED, i_GAIN_SHIFT, i_FMT,
    input  o_I2S_BCLK, o_I2S_LRCK, o_I2S_SDATA, o_FRAME_STRB,
           o_OVERRUN_CNT, o_UNDERRUN_CNT
  );

  modport slave (
    input  i_ACC_SIGNED_STRB, i_ACC_SIGNED, i_GAIN_SHIFT, i_FMT,
    output o_I2S_BCLK, o_I2S_LRCK, o_I2S_SDATA, o_FRAME_STRB,
           o_OVERRUN_CNT, o_UNDERRUN_CNT
  );

endinterface

// File: rtl/ikaopll_i2s_clkgen.sv
// Free-running BCLK divider with falling-edge pulse, 32-slot bit counter and LRCK.
module ikaopll_i2s_clkgen
  import ikaopll_i2s_out_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 4
) (
  input  logic i_EMUCLK,
  input  logic i_RST_n,
  output logic o_bclk,
  output logic o_lrck,
  output logic o_fe,
  output logic o_frame_start
);

  localparam int              DIV_W    = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             lrck_q, lrck_d;
  logic [BIT_W-1:0] bit_nxt;
  logic             wrap;
  logic             fe;

  always_comb begin
    wrap    = (div_q == DIV_LAST);
    div_d   = wrap ? '0 : div_q + DIV_W'(1);
    bclk_d  = wrap ? ~bclk_q : bclk_q;
    fe      = wrap & bclk_q;
    // Natural 5-bit wrap gives the mod-32 slot count.
    bit_nxt = bit_q + BIT_W'(1);
    bit_d   = fe ? bit_nxt : bit_q;
    lrck_d  = fe ? bit_nxt[BIT_W-1] : lrck_q;
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= BIT_W'(FRAME_BITS - 1);
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      bit_q  <= bit_d;
      lrck_q <= lrck_d;
    end
  end

  assign o_bclk        = bclk_q;
  assign o_lrck        = lrck_q;
  assign o_fe          = fe;
  assign o_frame_start = fe && (bit_nxt == '0);

endmodule

// File: rtl/ikaopll_i2s_out.sv
// OPLL sample to I2S / left-justified serialiser: gain+saturation, single-entry hold with
// pending flag, mono-duplicated 2x16-bit frames, overrun/underrun statistics.
module ikaopll_i2s_out
  import ikaopll_i2s_out_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 4
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST_n,
  ikaopll_i2s_out_if.slave   bus
);

  logic fe;
  logic frame_start;

  ikaopll_i2s_clkgen #(
    .BCLK_HALF_DIV (BCLK_HALF_DIV)
  ) u_clkgen (
    .i_EMUCLK      (i_EMUCLK),
    .i_RST_n       (i_RST_n),
    .o_bclk        (bus.o_I2S_BCLK),
    .o_lrck        (bus.o_I2S_LRCK),
    .o_fe          (fe),
    .o_frame_start (frame_start)
  );

  logic                  strb_z_q,  strb_z_d;
  logic [ACC_W-1:0]      hold_q,    hold_d;
  logic                  pending_q, pending_d;
  logic [ACC_W-1:0]      word_q,    word_d;
  logic [FRAME_BITS-1:0] sr_q,      sr_d;
  logic                  dly_q,     dly_d;
  logic                  sdata_q,   sdata_d;
  logic                  fstrb_q,   fstrb_d;
  logic [CNT_W-1:0]      ovr_q,     ovr_d;
  logic [CNT_W-1:0]      und_q,     und_d;

  logic             cap;
  logic             lj_bit;
  logic [ACC_W-1:0] word_sel;

  always_comb begin
    strb_z_d  = bus.i_ACC_SIGNED_STRB;
    hold_d    = hold_q;
    pending_d = pending_q;
    word_d    = word_q;
    sr_d      = sr_q;
    dly_d     = dly_q;
    sdata_d   = sdata_q;
    fstrb_d   = 1'b0;
    ovr_d     = ovr_q;
    und_d     = und_q;
    lj_bit    = 1'b0;

    cap      = bus.i_ACC_SIGNED_STRB & ~strb_z_q;
    word_sel = pending_q ? hold_q : word_q;

    if (fe) begin
      if (frame_start) begin
        fstrb_d = 1'b1;
        word_d  = word_sel;
        sr_d    = {word_sel, word_sel};
        lj_bit  = word_sel[ACC_W-1];
        if (pending_q)
          pending_d = 1'b0;
        else
          und_d = sat_inc(und_q);
      end else begin
        sr_d   = sr_q << 1;
        lj_bit = sr_q[FRAME_BITS-2];
      end
      // I2S trails the left-justified stream by one BCLK; the delay bit carries across frames.
      sdata_d = (fmt_e'(bus.i_FMT) == FMT_LJ) ? lj_bit : dly_q;
      dly_d   = lj_bit;
    end

    // Capture after the load so a same-cycle load still sees the previous hold.
    if (cap) begin
      hold_d    = sat_shift(bus.i_ACC_SIGNED, bus.i_GAIN_SHIFT);
      pending_d = 1'b1;
      if (pending_q && !frame_start)
        ovr_d = sat_inc(ovr_q);
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      strb_z_q  <= 1'b0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      word_q    <= '0;
      sr_q      <= '0;
      dly_q     <= 1'b0;
      sdata_q   <= 1'b0;
      fstrb_q   <= 1'b0;
      ovr_q     <= '0;
      und_q     <= '0;
    end else begin
      strb_z_q  <= strb_z_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      word_q    <= word_d;
      sr_q      <= sr_d;
      dly_q     <= dly_d;
      sdata_q   <= sdata_d;
      fstrb_q   <= fstrb_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
    end
  end

  assign bus.o_I2S_SDATA    = sdata_q;
  assign bus.o_FRAME_STRB   = fstrb_q;
  assign bus.o_OVERRUN_CNT  = ovr_q;
  assign bus.o_UNDERRUN_CNT = und_q;

endmodule

// File: tb/tb_ikaopll_i2s_out.sv
// Bench for ikaopll_i2s_out: event-level reference model checked every cycle, plus
// table-driven gain/saturation vectors and hand-built timing corner cases.
module tb_ikaopll_i2s_out;
  import ikaopll_i2s_out_pkg::*;

  localparam int DIV       = 2;
  localparam int FE_PER    = 2 * DIV;
  localparam int FRAME_CYC = FE_PER * 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ikaopll_i2s_out_if bus();

  ikaopll_i2s_out #(.BCLK_HALF_DIV(DIV)) dut (
    .i_EMUCLK (clk),
    .i_RST_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_n;
  logic [15:0] m_hold, m_word;
  logic        m_pend;
  int          m_ovr, m_und;
  logic        m_strb_prev, m_prev_l, m_sdata, m_fstrb;
  logic        ev_fe, ev_fs;
  logic [31:0] cap_sr;

  typedef struct {
    logic [15:0] acc;
    logic [1:0]  sh;
    logic [15:0] exp_w;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_sat(input logic [15:0] a, input logic [1:0] sh);
    int v;
    v = int'($signed(a)) * (1 << sh);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // One clock edge of the behavioural model; timing derived from the edge count since reset.
  task automatic model_edge();
    logic cap, pend_before, l_bit;
    int   k, pos;
    ev_fe = 1'b0;
    ev_fs = 1'b0;
    if (!rst_n) begin
      m_n = 0; m_hold = '0; m_word = '0; m_pend = 1'b0; m_ovr = 0; m_und = 0;
      m_strb_prev = 1'b0; m_prev_l = 1'b0; m_sdata = 1'b0; m_fstrb = 1'b0;
      return;
    end
    m_n++;
    m_fstrb     = 1'b0;
    cap         = bus.i_ACC_SIGNED_STRB && !m_strb_prev;
    m_strb_prev = bus.i_ACC_SIGNED_STRB;
    pend_before = m_pend;
    if (m_n % FE_PER == 0) begin
      ev_fe = 1'b1;
      k     = m_n / FE_PER;
      pos   = (k - 1) % 32;
      if (pos == 0) begin
        ev_fs   = 1'b1;
        m_fstrb = 1'b1;
        if (pend_before) begin
          m_word = m_hold;
          m_pend = 1'b0;
        end else if (m_und < 255) begin
          m_und++;
        end
      end
      l_bit    = m_word[15 - (pos % 16)];
      m_sdata  = bus.i_FMT ? l_bit : m_prev_l;
      m_prev_l = l_bit;
    end
    if (cap) begin
      if (pend_before && !ev_fs && m_ovr < 255) m_ovr++;
      m_hold = ref_sat(bus.i_ACC_SIGNED, bus.i_GAIN_SHIFT);
      m_pend = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int   k;
    logic exp_b, exp_l;
    exp_b = ((m_n / DIV) % 2) == 1;
    k     = m_n / FE_PER;
    exp_l = (k == 0) ? 1'b0 : (((k - 1) % 32) >= 16);
    check("outs",
          {12'h0, bus.o_I2S_BCLK, bus.o_I2S_LRCK, bus.o_I2S_SDATA, bus.o_FRAME_STRB,
           bus.o_OVERRUN_CNT, bus.o_UNDERRUN_CNT},
          {12'h0, exp_b, exp_l, m_sdata, m_fstrb, 8'(m_ovr), 8'(m_und)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
    if (ev_fe) cap_sr = {cap_sr[30:0], bus.o_I2S_SDATA};
  endtask

  task automatic wait_frame();
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!bus.o_FRAME_STRB && guard < 2 * FRAME_CYC);
    if (!bus.o_FRAME_STRB) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no FRAME_STRB within %0d cycles", guard);
    end
  endtask

  // Collect the 32 SDATA bits of the next frame, bit 0 of the frame in f[31].
  task automatic collect_frame(output logic [31:0] f);
    wait_frame();
    repeat (31 * FE_PER) tick();
    f = cap_sr;
  endtask

  task automatic send_word(input logic [15:0] acc, input logic [1:0] sh);
    bus.i_ACC_SIGNED      = acc;
    bus.i_GAIN_SHIFT      = sh;
    bus.i_ACC_SIGNED_STRB = 1'b1;
    tick();
    bus.i_GAIN_SHIFT = ~sh;
    repeat (2) tick();
    bus.i_ACC_SIGNED_STRB = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] f, g;
    int          cnt;

    vecs[0]  = '{16'h1234, 2'd0, 16'h1234};
    vecs[1]  = '{16'h1000, 2'd3, 16'h7FFF};
    vecs[2]  = '{16'hF000, 2'd3, 16'h8000};
    vecs[3]  = '{16'h0FFF, 2'd3, 16'h7FF8};
    vecs[4]  = '{16'h8001, 2'd0, 16'h8001};
    vecs[5]  = '{16'hFFFF, 2'd1, 16'hFFFE};
    vecs[6]  = '{16'h4000, 2'd1, 16'h7FFF};
    vecs[7]  = '{16'hC000, 2'd1, 16'h8000};
    vecs[8]  = '{16'hBFFF, 2'd1, 16'h8000};
    vecs[9]  = '{16'h3FFF, 2'd1, 16'h7FFE};
    vecs[10] = '{16'h0001, 2'd3, 16'h0008};
    vecs[11] = '{16'h8000, 2'd0, 16'h8000};

    bus.i_ACC_SIGNED_STRB = 1'b0;
    bus.i_ACC_SIGNED      = '0;
    bus.i_GAIN_SHIFT      = '0;
    bus.i_FMT             = 1'b1;
    cap_sr                = '0;

    // reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outs", {bus.o_I2S_BCLK, bus.o_I2S_LRCK, bus.o_I2S_SDATA, bus.o_FRAME_STRB,
                         bus.o_OVERRUN_CNT, bus.o_UNDERRUN_CNT}, 32'h0);
    rst_n = 1'b1;
    cnt   = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.o_FRAME_STRB && cnt < 20);
    check("first_frame_cycle", cnt, 4);
    check("first_underrun", bus.o_UNDERRUN_CNT, 1);
    repeat (FRAME_CYC) tick();
    check("second_frame_strb", bus.o_FRAME_STRB, 1);
    check("second_underrun", bus.o_UNDERRUN_CNT, 2);

    // gain / saturation table, left-justified
    for (int i = 0; i < 12; i++) begin
      wait_frame();
      repeat (8) tick();
      send_word(vecs[i].acc, vecs[i].sh);
      collect_frame(f);
      check($sformatf("vec%0d_frame", i), f, {vecs[i].exp_w, vecs[i].exp_w});
    end

    // I2S delay: MSB one BCLK late, right LSB spills into next frame bit 0
    bus.i_FMT = 1'b0;
    wait_frame();
    repeat (8) tick();
    send_word(16'h8001, 2'd0);
    collect_frame(f);
    check("i2s_word_bits1_16", f[30:15], 16'h8001);
    check("i2s_right_msbs", f[14:0], 15'h4000);
    collect_frame(g);
    check("i2s_lsb_next_frame", g[31], 1'b1);

    // overrun: two captures between frames
    bus.i_FMT = 1'b1;
    wait_frame();
    repeat (4) tick();
    send_word(16'h0001, 2'd0);
    send_word(16'h0002, 2'd0);
    collect_frame(f);
    check("overrun_frame", f, 32'h00020002);
    check("overrun_cnt", bus.o_OVERRUN_CNT, 1);

    // capture in the exact load cycle, strobe then held high for 300 cycles
    wait_frame();
    repeat (8) tick();
    send_word(16'h1111, 2'd0);
    repeat (FRAME_CYC - 12 - 1) tick();
    bus.i_ACC_SIGNED      = 16'h2222;
    bus.i_GAIN_SHIFT      = 2'd0;
    bus.i_ACC_SIGNED_STRB = 1'b1;
    collect_frame(f);
    check("collide_old_word", f, 32'h11111111);
    collect_frame(g);
    check("collide_new_word", g, 32'h22222222);
    check("collide_no_overrun", bus.o_OVERRUN_CNT, 1);
    repeat (300 - 2 * FRAME_CYC + 3) tick();
    bus.i_ACC_SIGNED_STRB = 1'b0;
    collect_frame(f);
    check("held_strb_repeat", f, 32'h22222222);

    // underrun saturation
    repeat (260 * FRAME_CYC) tick();
    check("underrun_sat", bus.o_UNDERRUN_CNT, 255);
    repeat (3 * FRAME_CYC) tick();
    check("underrun_stays", bus.o_UNDERRUN_CNT, 255);

    // reset mid-frame restarts timing from scratch
    wait_frame();
    repeat (50) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("midreset_outs", {bus.o_I2S_BCLK, bus.o_I2S_LRCK, bus.o_I2S_SDATA, bus.o_FRAME_STRB,
                            bus.o_OVERRUN_CNT, bus.o_UNDERRUN_CNT}, 32'h0);
    rst_n = 1'b1;
    cnt   = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.o_FRAME_STRB && cnt < 20);
    check("midreset_first_frame", cnt, 4);

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 150)) tick();
      if ($urandom_range(0, 3) == 0) bus.i_FMT = 1'($urandom_range(0, 1));
      bus.i_ACC_SIGNED      = 16'($urandom);
      bus.i_GAIN_SHIFT      = 2'($urandom_range(0, 3));
      bus.i_ACC_SIGNED_STRB = 1'b1;
      repeat ($urandom_range(1, 6)) tick();
      bus.i_ACC_SIGNED_STRB = 1'b0;
    end
    repeat (2 * FRAME_CYC) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
